inst_loader: RTL and testbench
==============================

# inst_loader

Byte-stream program loader that writes the instruction memory the fetch path later reads. It is the write-side counterpart to the instruction ROM. It accepts a framed byte stream over a valid/ready handshake, then unpacks each W-bit instruction from two bytes. It writes each word into instruction RAM at consecutive addresses from a base address and checks the frame with a length header and XOR checksum. It sits between the host/testbench byte source and the write port of the instruction RAM that replaces the preloaded ROM image.

## Interface
- A, 16, instruction address width
- W, 9, instruction width; W must be 9..16 (two bytes per word)

- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle pulse; begins a frame load (ignored unless idle)
- BaseAddr  in  A  first write address, sampled on accepted Start
- InData  in  8  stream byte
- InValid  in  1  InData valid
- InReady  out  1  loader accepts a byte this cycle
- WrEn  out  1  instruction RAM write strobe
- WrAddr  out  A  RAM write address
- WrData  out  W  RAM write data
- Busy  out  1  frame in progress
- Done  out  1  one-cycle pulse at frame end (success or error)
- Err  out  1  frame error; valid with Done, held until next accepted Start or Reset
- WordCount  out  A+1  words written in current/last frame

## Operation
- Frame: LEN_LO, LEN_HI (N, 16-bit little-endian), then N words as (LO = word[7:0], HI = word[W-1:8] in low bits), then CK = XOR of all frame bytes before it, LEN bytes included.
- A byte is accepted when InValid && InReady at a rising edge. InReady = 1 in every receiving state and 0 in IDLE and FINISH.
- States: IDLE -> (Start) S_LEN_LO -> S_LEN_HI -> S_WORD_LO <-> S_WORD_HI -> S_CK -> FINISH -> IDLE.
- S_LEN_HI goes straight to S_CK when N = 0.
- S_WORD_HI goes back to S_WORD_LO while words remain, else to S_CK.
- Range error: at S_LEN_HI acceptance, if BaseAddr + N > 2**A (computed A+1 bits wide), set Err and go to FINISH. Nothing is written.
- Format error: a HI byte with nonzero bits [7:W-8] sets Err. That word is not written. The loader goes to FINISH at once and the remaining bytes are not consumed.
- Checksum error: a CK byte that mismatches the running XOR sets Err in FINISH. Words already written stay written.
- FINISH lasts one cycle: Done = 1, Busy = 0 next cycle, returns to IDLE.
- Start while not IDLE is ignored. Reset mid-frame aborts immediately to IDLE with outputs at reset values and no Done.
- WrAddr = latched BaseAddr + word index, in A-bit arithmetic. No wrap can occur because of the range check.

## Timing
- Reset values: InReady 0, WrEn 0, WrAddr 0, WrData 0, Busy 0, Done 0, Err 0, WordCount 0, state IDLE.
- Start accepted in cycle t: Busy = 1 and InReady = 1 from t+1.
- Write latency:
  - WrEn is registered and high for exactly the one cycle after the HI byte is accepted.
  - WrAddr and WrData are valid in that cycle.
  - WordCount increments in that same cycle.
- Throughput is one byte per cycle, so at most one write every two cycles.
- Done pulses the cycle after the CK byte is accepted, or the cycle after the erroring byte is accepted.
- Err changes only at accepted Start (cleared), at Reset (cleared), or on entry to FINISH.
- InValid low stalls any receiving state indefinitely with no timeout.

## Structure
- Shared package loader_pkg: state enum, LEN_BYTES = 2, BYTES_PER_WORD = 2.
- One sub-module is natural: loader_cksum, a running XOR accumulator with clear and enable.
- Everything else is a single FSM plus datapath registers: length, index, base, low-byte holding register.

## Test plan
- BaseAddr = 0x0010, frame N = 3, words 0x1A5, 0x003, 0x100, correct CK.
  - Expect writes to 0x0010/0x0011/0x0012 with those values.
  - Expect Done = 1, Err = 0, WordCount = 3.
- N = 0 with CK = 0x00 -> no WrEn, Done 4 cycles after Start (2 LEN bytes, CK, FINISH), Err = 0.
- N = 2, CK off by one bit -> both words written, Done with Err = 1. A following Start clears Err.
- Second word HI byte = 0x02 (W = 9) -> only first word written, Err = 1. Done follows the bad byte, InReady = 0 afterward.
- BaseAddr = 0xFFFF, N = 2 -> Err = 1 after LEN_HI, no writes.
  - BaseAddr = 0xFFFE, N = 2 -> writes 0xFFFE and 0xFFFF, Err = 0.
- Random InValid gaps during a 4-word frame -> identical writes.
  - Reset asserted after the first write -> all outputs 0 next cycle, no Done.
  - A new Start then loads normally.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-RAM byte-stream loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_WORD_LO,
        ST_WORD_HI,
        ST_CK,
        ST_FINISH
    } state_e;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 2;

    // True when a HI byte carries bits above the top of a w-bit word.
    function automatic logic hi_bad(input logic [7:0] b, input int w);
        return (b >> (w - (BYTES_PER_WORD - 1) * 8)) != 8'd0;
    endfunction

endpackage

// File: rtl/loader_cksum.sv
// Running XOR of frame bytes, cleared at frame start.
module loader_cksum (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sum_q <= 8'd0;
        end else if (en_i) begin
            sum_q <= sum_q ^ data_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/inst_loader.sv
// Framed byte-stream loader writing W-bit words into instruction RAM.
module inst_loader
    import loader_pkg::*;
#(
    parameter int A = 16,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] BaseAddr,
    input  logic [7:0]   InData,
    input  logic         InValid,
    output logic         InReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         Busy,
    output logic         Done,
    output logic         Err,
    output logic [A:0]   WordCount
);

    localparam int LW = LEN_BYTES * 8;
    localparam int SW = ((A > LW) ? A : LW) + 2;

    state_e        state_q;
    logic [LW-1:0] len_q;
    logic [A:0]    idx_q;
    logic [A-1:0]  base_q;
    logic [7:0]    lo_q;
    logic          wr_en_q;
    logic [A-1:0]  wr_addr_q;
    logic [W-1:0]  wr_data_q;
    logic          err_q;

    logic          accept;
    logic          start_ok;
    logic          ck_en;
    logic [7:0]    ck_sum;
    logic [LW-1:0] len_d;
    logic [SW-1:0] end_addr;
    logic          range_bad;
    logic          more_words;

    assign InReady = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     (state_q == ST_WORD_LO) || (state_q == ST_WORD_HI) ||
                     (state_q == ST_CK);
    assign accept   = InValid && InReady;
    assign start_ok = Start && (state_q == ST_IDLE);
    assign ck_en    = accept && (state_q != ST_CK);

    assign len_d      = {InData, len_q[7:0]};
    assign end_addr   = SW'(base_q) + SW'(len_d);
    assign range_bad  = end_addr > (SW'(1) << A);
    assign more_words = (SW'(idx_q) + SW'(1)) < SW'(len_q);

    loader_cksum u_cksum (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .clr_i  (start_ok),
        .en_i   (ck_en),
        .data_i (InData),
        .sum_o  (ck_sum)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            base_q    <= '0;
            lo_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        base_q  <= BaseAddr;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= InData;
                        state_q    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_q <= len_d;
                        if (range_bad) begin
                            err_q   <= 1'b1;
                            state_q <= ST_FINISH;
                        end else if (len_d == '0) begin
                            state_q <= ST_CK;
                        end else begin
                            state_q <= ST_WORD_LO;
                        end
                    end
                end
                ST_WORD_LO: begin
                    if (accept) begin
                        lo_q    <= InData;
                        state_q <= ST_WORD_HI;
                    end
                end
                ST_WORD_HI: begin
                    if (accept) begin
                        if (hi_bad(InData, W)) begin
                            err_q   <= 1'b1;
                            state_q <= ST_FINISH;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= base_q + idx_q[A-1:0];
                            wr_data_q <= {InData[W-9:0], lo_q};
                            idx_q     <= idx_q + 1'b1;
                            state_q   <= more_words ? ST_WORD_LO : ST_CK;
                        end
                    end
                end
                ST_CK: begin
                    if (accept) begin
                        if (InData != ck_sum) begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign WrEn      = wr_en_q;
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;
    assign Busy      = (state_q != ST_IDLE);
    assign Done      = (state_q == ST_FINISH);
    assign Err       = err_q;
    assign WordCount = idx_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: frame table plus corner sequences.
module tb_inst_loader;

    localparam int A = 16;
    localparam int W = 9;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [A-1:0] BaseAddr;
    logic [7:0]   InData;
    logic         InValid;
    logic         InReady;
    logic         WrEn;
    logic [A-1:0] WrAddr;
    logic [W-1:0] WrData;
    logic         Busy;
    logic         Done;
    logic         Err;
    logic [A:0]   WordCount;

    inst_loader #(.A(A), .W(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .BaseAddr  (BaseAddr),
        .InData    (InData),
        .InValid   (InValid),
        .InReady   (InReady),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .WordCount (WordCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] data;
        logic [A:0]   cnt;
    } wr_t;

    typedef struct {
        logic [A-1:0] base;
        logic [15:0]  n;
        logic [W-1:0] w [4];
        bit           flip;
        bit           gaps;
        bit           range;
        bit           exp_err;
        int           exp_cnt;
    } vec_t;

    wr_t  sbq[$];
    vec_t vecs[5];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        wr_t e;
        if (WrEn === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         WrAddr, WrData);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", 32'(WrAddr), 32'(e.addr));
                chk("wr_data", 32'(WrData), 32'(e.data));
                chk("wr_count", 32'(WordCount), 32'(e.cnt));
            end
        end
    end

    function automatic vec_t mk(input logic [A-1:0] base, input logic [15:0] n,
                                input logic [W-1:0] w0, input logic [W-1:0] w1,
                                input logic [W-1:0] w2, input logic [W-1:0] w3,
                                input bit flip, input bit gaps, input bit range,
                                input bit exp_err, input int exp_cnt);
        vec_t v;
        v.base = base;
        v.n = n;
        v.w[0] = w0;
        v.w[1] = w1;
        v.w[2] = w2;
        v.w[3] = w3;
        v.flip = flip;
        v.gaps = gaps;
        v.range = range;
        v.exp_err = exp_err;
        v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic start_frame(input logic [A-1:0] base);
        Start = 1'b1;
        BaseAddr = base;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b, input bit gap);
        bit ok;
        ok = 0;
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                InValid = 1'b0;
                @(negedge Clk);
            end
        end
        InValid = 1'b1;
        InData = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (InReady === 1'b1) ok = 1;
            @(negedge Clk);
        end
        if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (Done !== 1'b1 && lat < 100) begin
            @(negedge Clk);
            lat++;
        end
    endtask

    task automatic run_frame(input vec_t v, input bit chk_clear);
        logic [7:0] lo, hi, ck;
        int lat;
        start_frame(v.base);
        if (chk_clear) chk("err_clear_on_start", 32'(Err), 32'd0);
        chk("busy_after_start", 32'(Busy), 32'd1);
        lo = v.n[7:0];
        hi = v.n[15:8];
        ck = lo ^ hi;
        put_byte(lo, v.gaps);
        put_byte(hi, v.gaps);
        if (!v.range) begin
            for (int j = 0; j < int'(v.n); j++) begin
                lo = v.w[j][7:0];
                hi = 8'(v.w[j] >> 8);
                ck = ck ^ lo ^ hi;
                sbq.push_back('{addr: v.base + A'(j), data: v.w[j],
                                cnt: (A+1)'(j + 1)});
                put_byte(lo, v.gaps);
                put_byte(hi, v.gaps);
            end
            put_byte(ck ^ {7'd0, v.flip}, v.gaps);
        end
        wait_done(lat);
        chk("done_latency", 32'(lat), 32'd0);
        chk("frame_err", 32'(Err), 32'(v.exp_err));
        chk("frame_count", 32'(WordCount), 32'(v.exp_cnt));
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        InValid = 1'b0;
        @(negedge Clk);
        chk("idle_after_done", 32'({Busy, Done, InReady}), 32'd0);
    endtask

    initial begin
        int k;
        vecs[0] = mk(16'h0010, 16'd3, 9'h1A5, 9'h003, 9'h100, 9'h000, 0, 0, 0, 0, 3);
        vecs[1] = mk(16'h0020, 16'd2, 9'h0FF, 9'h1FF, 9'h000, 9'h000, 1, 0, 0, 1, 2);
        vecs[2] = mk(16'hFFFE, 16'd2, 9'h001, 9'h1FE, 9'h000, 9'h000, 0, 0, 0, 0, 2);
        vecs[3] = mk(16'h0100, 16'd4, 9'h111, 9'h022, 9'h1C3, 9'h004, 0, 1, 0, 0, 4);
        vecs[4] = mk(16'hFFFF, 16'd2, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 1, 1, 0);

        Reset = 1'b1;
        Start = 1'b0;
        BaseAddr = '0;
        InData = '0;
        InValid = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_outputs", 32'({InReady, WrEn, WrAddr, WrData, Busy, Done, Err}), 32'd0);
        chk("reset_count", 32'(WordCount), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 5; i++) run_frame(vecs[i], i > 0);

        // Empty frame: all-zero bytes streamed back to back from Start
        Start = 1'b1;
        BaseAddr = 16'h0500;
        InValid = 1'b1;
        InData = 8'h00;
        k = 0;
        do begin
            @(negedge Clk);
            Start = 1'b0;
            k++;
            if (k == 1) chk("n0_ready", 32'({Busy, InReady}), 32'd3);
        end while (Done !== 1'b1 && k < 50);
        chk("n0_done_cycle", 32'(k), 32'd4);
        chk("n0_err", 32'(Err), 32'd0);
        chk("n0_count", 32'(WordCount), 32'd0);
        InValid = 1'b0;
        @(negedge Clk);

        // Format error on the second word's HI byte
        start_frame(16'h0040);
        put_byte(8'd3, 0);
        put_byte(8'd0, 0);
        sbq.push_back('{addr: 16'h0040, data: 9'h0AB, cnt: 17'd1});
        put_byte(8'hAB, 0);
        put_byte(8'h00, 0);
        put_byte(8'h55, 0);
        put_byte(8'h02, 0);
        chk("fmt_done", 32'(Done), 32'd1);
        chk("fmt_err", 32'(Err), 32'd1);
        chk("fmt_count", 32'(WordCount), 32'd1);
        chk("fmt_ready_low", 32'(InReady), 32'd0);
        @(negedge Clk);
        chk("fmt_idle", 32'({Busy, Done, InReady}), 32'd0);
        chk("fmt_err_held", 32'(Err), 32'd1);
        chk("fmt_sb_empty", 32'(sbq.size()), 32'd0);
        InValid = 1'b0;
        @(negedge Clk);

        // Reset right after the first write of a 4-word frame
        start_frame(16'h0200);
        put_byte(8'd4, 1);
        put_byte(8'd0, 1);
        sbq.push_back('{addr: 16'h0200, data: 9'h1EE, cnt: 17'd1});
        put_byte(8'hEE, 1);
        put_byte(8'h01, 1);
        chk("pre_reset_wren", 32'(WrEn), 32'd1);
        Reset = 1'b1;
        InValid = 1'b0;
        @(negedge Clk);
        chk("mid_reset_outputs",
            32'({InReady, WrEn, WrAddr, WrData, Busy, Done, Err}), 32'd0);
        chk("mid_reset_count", 32'(WordCount), 32'd0);
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("no_done_after_reset", 32'(Done), 32'd0);
        end
        run_frame(mk(16'h0300, 16'd1, 9'h155, 9'h000, 9'h000, 9'h000,
                     0, 0, 0, 0, 1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
